// File: rtl/bus_burst_master.sv
// Burst engine between the cache refill/writeback clients and the core memory bus.
// Accepts one read or write burst (1..MAX_LEN words) at a time and reports completion
// with a one-cycle done pulse and an error flag.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           client request handshake (ready only while idle)
//   req_write, req_addr, req_len  burst direction, start address, word count
//   wr_data_valid/wr_data/wr_data_ready  client write-word stream
//   rd_data_valid/rd_data/rd_last        client read-word stream (no backpressure)
//   done, err                     completion pulse and error flag
//   bus_req, bus_resp             memory bus request / response fields

package bus_burst_master_pkg;

    typedef logic [31:0] paddr_t;

    typedef struct packed {
        logic        awvalid;
        paddr_t      waddr;
        logic [3:0]  wlen;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
        logic        arvalid;
        paddr_t      araddr;
        logic [3:0]  rlen;
        logic        rready;
    } bus_query_req_t;

    // rready here acknowledges the read address, not read data.
    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic        rready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } bus_query_resp_t;

endpackage

module bus_burst_master
    import bus_burst_master_pkg::*;
#(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  paddr_t          req_addr,
    input  logic [3:0]      req_len,
    input  logic            wr_data_valid,
    input  logic [31:0]     wr_data,
    output logic            wr_data_ready,
    output logic            rd_data_valid,
    output logic [31:0]     rd_data,
    output logic            rd_last,
    output logic            done,
    output logic            err,
    output bus_query_req_t  bus_req,
    input  bus_query_resp_t bus_resp
);

    typedef enum logic [2:0] {
        StIdle,
        StWAddr,
        StWData,
        StWResp,
        StRAddr,
        StRData,
        StFin
    } state_e;

    // Direction is carried by the state encoding, so no separate write flag is kept.
    state_e     state_q, state_d;
    paddr_t     addr_q, addr_d;
    logic [3:0] len_q, len_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic       last_beat;
    paddr_t     addr_aligned;

    assign last_beat    = (cnt_q == len_q - 4'd1);
    assign addr_aligned = addr_q & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        req_ready     = 1'b0;
        wr_data_ready = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        rd_last       = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        bus_req       = '0;

        unique case (state_q)
            StIdle: begin
                // Gate with rst_n so req_ready reads 0 while reset is held.
                req_ready = rst_n;
                if (req_valid) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (req_len == 4'd0 || 32'(req_len) > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = req_write ? StWAddr : StRAddr;
                    end
                end
            end
            StWAddr: begin
                bus_req.awvalid = 1'b1;
                bus_req.waddr   = addr_aligned;
                bus_req.wlen    = len_q;
                if (bus_resp.awready) state_d = StWData;
            end
            StWData: begin
                bus_req.wvalid = wr_data_valid;
                bus_req.wdata  = wr_data;
                bus_req.wstrb  = 4'hF;
                bus_req.wlast  = last_beat;
                wr_data_ready  = wr_data_valid & bus_resp.wready;
                if (wr_data_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last_beat) state_d = StWResp;
                end
            end
            StWResp: begin
                bus_req.bready = 1'b1;
                if (bus_resp.bvalid) state_d = StFin;
            end
            StRAddr: begin
                bus_req.arvalid = 1'b1;
                bus_req.araddr  = addr_aligned;
                bus_req.rlen    = len_q;
                if (bus_resp.rready) state_d = StRData;
            end
            StRData: begin
                bus_req.rready = 1'b1;
                if (bus_resp.rvalid) begin
                    rd_data_valid = 1'b1;
                    rd_data       = bus_resp.rdata;
                    rd_last       = bus_resp.rlast | last_beat;
                    cnt_d         = cnt_q + 4'd1;
                    if (bus_resp.rlast) begin
                        // Early rlast: burst ends short and is flagged.
                        if (!last_beat) err_d = 1'b1;
                        state_d = StFin;
                    end else if (last_beat) begin
                        // Slave overran the length; remaining beats are dropped.
                        err_d   = 1'b1;
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_bus_burst_master.sv
// Testbench for bus_burst_master: directed bursts with a scoreboard.
// Stimulus pushes expected address phases, data beats and completions into queues;
// a monitor pops and compares whenever the DUT presents the matching output.

module tb_bus_burst_master;
    import bus_burst_master_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    paddr_t          req_addr;
    logic [3:0]      req_len;
    logic            wr_data_valid;
    logic [31:0]     wr_data;
    logic            wr_data_ready;
    logic            rd_data_valid;
    logic [31:0]     rd_data;
    logic            rd_last;
    logic            done;
    logic            err;
    bus_query_req_t  bus_req;
    bus_query_resp_t bus_resp;

    int total = 0;
    int bad   = 0;
    int addr_cycles = 0;

    // Expected entries: aw/ar = {len, addr}; w/rd = {last, data}; done = err.
    logic [35:0] aw_q[$];
    logic [35:0] ar_q[$];
    logic [35:0] w_q[$];
    logic [35:0] rd_q[$];
    logic [35:0] done_q[$];

    logic [31:0] dv [4];

    bus_burst_master #(.MAX_LEN(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_data_valid(wr_data_valid),
        .wr_data      (wr_data),
        .wr_data_ready(wr_data_ready),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .done         (done),
        .err          (err),
        .bus_req      (bus_req),
        .bus_resp     (bus_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_req.awvalid || bus_req.arvalid) addr_cycles++;
                if (bus_req.awvalid && bus_resp.awready) begin
                    if (aw_q.size() == 0) chk("unexpected_aw", 36'd1, 36'd0);
                    else chk("aw_phase", {bus_req.wlen, bus_req.waddr}, aw_q.pop_front());
                end
                if (bus_req.arvalid && bus_resp.rready) begin
                    if (ar_q.size() == 0) chk("unexpected_ar", 36'd1, 36'd0);
                    else chk("ar_phase", {bus_req.rlen, bus_req.araddr}, ar_q.pop_front());
                end
                if (bus_req.wvalid && bus_resp.wready) begin
                    if (w_q.size() == 0) chk("unexpected_w", 36'd1, 36'd0);
                    else begin
                        chk("w_beat", 36'({bus_req.wlast, bus_req.wdata}), w_q.pop_front());
                        chk("w_strb", 36'(bus_req.wstrb), 36'hF);
                        chk("w_data_ready", 36'(wr_data_ready), 36'd1);
                    end
                end
                if (rd_data_valid) begin
                    if (rd_q.size() == 0) chk("unexpected_rd", 36'd1, 36'd0);
                    else chk("rd_beat", 36'({rd_last, rd_data}), rd_q.pop_front());
                end
                if (done) begin
                    if (done_q.size() == 0) chk("unexpected_done", 36'd1, 36'd0);
                    else chk("done_err", 36'(err), done_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic w, input paddr_t a, input logic [3:0] l);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 36'd0, 36'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Latency in cycles from acceptance: 1 = the cycle right after the accepting edge.
    task automatic wait_done(input int exp_lat, input string name);
        int k;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(name, 36'(k), 36'(exp_lat));
    endtask

    task automatic slave_read(input int n, input int last_at);
        int t = 0;
        while (!bus_req.arvalid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        bus_resp.rready = 1'b1;
        @(posedge clk); #1;
        bus_resp.rready = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = dv[i];
            bus_resp.rlast  = (i == last_at);
            @(posedge clk); #1;
        end
        bus_resp.rvalid = 1'b0;
        bus_resp.rlast  = 1'b0;
        bus_resp.rdata  = '0;
    endtask

    task automatic slave_write(input int aw_delay, input int n, input bit stall);
        int t = 0;
        while (!bus_req.awvalid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (aw_delay) begin
            @(posedge clk); #1;
        end
        bus_resp.awready = 1'b1;
        @(posedge clk); #1;
        bus_resp.awready = 1'b0;
        bus_resp.wready  = 1'b1;
        @(posedge clk); #1;
        if (stall) begin
            bus_resp.wready = 1'b0;
            @(negedge clk);
            chk("w_stall_hold", 36'({bus_req.wvalid, bus_req.wlast, wr_data_ready}), 36'b100);
            @(posedge clk); #1;
            bus_resp.wready = 1'b1;
        end
        repeat (n - 1) begin
            @(posedge clk); #1;
        end
        bus_resp.wready = 1'b0;
        bus_resp.bvalid = 1'b1;
        @(posedge clk); #1;
        bus_resp.bvalid = 1'b0;
    endtask

    task automatic client_write(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            wr_data_valid = 1'b1;
            wr_data       = dv[i];
            @(negedge clk);
            while (!wr_data_ready && t < 40) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk); #1;
        end
        wr_data_valid = 1'b0;
        wr_data       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data_valid = 1'b0; wr_data = '0;
        bus_resp = '0;
        #1 rst_n = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_req_ready", 36'(req_ready), 36'd0);
        chk("rst_bus_req", 36'(bus_req != '0), 36'd0);
        chk("rst_done", 36'({done, err, wr_data_ready, rd_data_valid}), 36'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 36'(req_ready), 36'd1);

        // Read burst, no wait states.
        dv = '{32'h11, 32'h22, 32'h33, 32'h44};
        ar_q.push_back({4'd4, 32'h8000_0004});
        rd_q.push_back(36'h0_0000_0011);
        rd_q.push_back(36'h0_0000_0022);
        rd_q.push_back(36'h0_0000_0033);
        rd_q.push_back(36'h1_0000_0044);
        done_q.push_back(36'd0);
        issue(1'b0, 32'h8000_0004, 4'd4);
        fork
            slave_read(4, 3);
            wait_done(6, "rd4_latency");
        join

        // Write burst with stalls on the address and the second beat.
        dv = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'h0};
        aw_q.push_back({4'd3, 32'h0000_1000});
        w_q.push_back(36'h0_A1A1_0001);
        w_q.push_back(36'h0_B2B2_0002);
        w_q.push_back(36'h1_C3C3_0003);
        done_q.push_back(36'd0);
        issue(1'b1, 32'h0000_1003, 4'd3);
        fork
            client_write(3);
            slave_write(2, 3, 1'b1);
            wait_done(9, "wr_stall_latency");
        join

        // Write burst, no wait states: len+3 cycles.
        dv = '{32'hDEAD_0001, 32'hBEEF_0002, 32'h0, 32'h0};
        aw_q.push_back({4'd2, 32'h0000_2000});
        w_q.push_back(36'h0_DEAD_0001);
        w_q.push_back(36'h1_BEEF_0002);
        done_q.push_back(36'd0);
        issue(1'b1, 32'h0000_2000, 4'd2);
        fork
            client_write(2);
            slave_write(0, 2, 1'b0);
            wait_done(5, "wr2_latency");
        join

        // Zero length: immediate error, no bus traffic.
        begin
            int snap;
            snap = addr_cycles;
            done_q.push_back(36'd1);
            issue(1'b0, 32'h0000_4000, 4'd0);
            wait_done(1, "zero_len_latency");
            chk("zero_len_no_bus", 36'(addr_cycles - snap), 36'd0);
        end

        // Early rlast on beat 2 of a 4-beat read.
        dv = '{32'h5555_0001, 32'h5555_0002, 32'h0, 32'h0};
        ar_q.push_back({4'd4, 32'h0000_5000});
        rd_q.push_back(36'h0_5555_0001);
        rd_q.push_back(36'h1_5555_0002);
        done_q.push_back(36'd1);
        issue(1'b0, 32'h0000_5000, 4'd4);
        fork
            slave_read(2, 1);
            wait_done(4, "early_rlast_latency");
        join

        // Following request behaves normally.
        dv = '{32'h0000_CAFE, 32'h0, 32'h0, 32'h0};
        ar_q.push_back({4'd1, 32'h0000_6008});
        rd_q.push_back(36'h1_0000_CAFE);
        done_q.push_back(36'd0);
        issue(1'b0, 32'h0000_600A, 4'd1);
        fork
            slave_read(1, 0);
            wait_done(3, "after_err_latency");
        join

        // Reset in the middle of a write data phase.
        aw_q.push_back({4'd4, 32'h0000_3000});
        w_q.push_back(36'h0_7777_0000);
        issue(1'b1, 32'h0000_3000, 4'd4);
        bus_resp.awready = 1'b1;
        @(posedge clk); #1;
        bus_resp.awready = 1'b0;
        bus_resp.wready  = 1'b1;
        wr_data_valid    = 1'b1;
        wr_data          = 32'h7777_0000;
        @(posedge clk); #1;
        wr_data = 32'h7777_0001;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_req", 36'(bus_req != '0), 36'd0);
        chk("mid_rst_client", 36'({req_ready, done, err, wr_data_ready, rd_data_valid, rd_last}),
            36'd0);
        chk("mid_rst_rd_data", 36'(rd_data), 36'd0);
        bus_resp = '0;
        wr_data_valid = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 36'(req_ready), 36'd1);

        dv = '{32'h0BAD_F00D, 32'h0, 32'h0, 32'h0};
        ar_q.push_back({4'd1, 32'h0000_7000});
        rd_q.push_back(36'h1_0BAD_F00D);
        done_q.push_back(36'd0);
        issue(1'b0, 32'h0000_7000, 4'd1);
        fork
            slave_read(1, 0);
            wait_done(3, "post_rst_rd_latency");
        join

        repeat (2) @(negedge clk);
        chk("left_aw", 36'(aw_q.size()), 36'd0);
        chk("left_ar", 36'(ar_q.size()), 36'd0);
        chk("left_w", 36'(w_q.size()), 36'd0);
        chk("left_rd", 36'(rd_q.size()), 36'd0);
        chk("left_done", 36'(done_q.size()), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
